// File: rtl/servo_motion_sequencer.sv
// servo_motion_sequencer: accepts 3-axis target angles, clamps them to the
// mechanical range, and slews the commanded angles toward the targets by at
// most STEP_DEG per update tick. After arrival it holds for a settle interval
// and then pulses done.
module servo_motion_sequencer #(
    parameter int FREQ         = 25_000_000,
    parameter int BIT_SIZE     = 10,
    parameter int TICK_DIV     = FREQ / 100,
    parameter int STEP_DEG     = 5,
    parameter int COORD_MAX    = 270,
    parameter int RESET_ANGLE  = 90,
    parameter int THRESHOLD    = 10,
    parameter int SETTLE_TICKS = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [BIT_SIZE-1:0] tgt_x,
    input  logic signed [BIT_SIZE-1:0] tgt_y,
    input  logic signed [BIT_SIZE-1:0] tgt_z,
    input  logic                       tgt_valid,
    output logic                       tgt_ready,
    input  logic                       stop,
    output logic signed [BIT_SIZE-1:0] cmd_x,
    output logic signed [BIT_SIZE-1:0] cmd_y,
    output logic signed [BIT_SIZE-1:0] cmd_z,
    output logic                       busy,
    output logic                       done
);

    localparam int W  = BIT_SIZE;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

    localparam logic [TW-1:0]        TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_TICKS - 1);
    localparam logic signed [W-1:0]  LIM_HI      = W'(COORD_MAX);
    localparam logic signed [W-1:0]  LIM_LO      = W'(-COORD_MAX);
    localparam logic signed [W-1:0]  RST_ANG     = W'(RESET_ANGLE);
    localparam logic signed [W-1:0]  STEP_W      = W'(STEP_DEG);
    localparam logic signed [W:0]    STEP_X      = (W+1)'(STEP_DEG);
    localparam logic signed [W:0]    THR_X       = (W+1)'(THRESHOLD);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE} state_t;

    state_t              r_state, w_state_next;
    logic [TW-1:0]       r_tick_cnt;
    logic [SW-1:0]       r_settle_cnt, w_settle_next;
    logic                r_done, w_done_next;
    logic signed [W-1:0] r_cmd [3];
    logic signed [W-1:0] r_tgt [3];
    logic signed [W-1:0] w_cmd_next [3];
    logic signed [W-1:0] w_tgt_next [3];
    logic signed [W-1:0] w_tgt_in [3];
    logic signed [W-1:0] w_clamped [3];
    logic signed [W-1:0] w_stepped [3];
    logic [2:0]          w_in_band;
    logic [2:0]          w_arrive;
    logic                w_tick;

    assign w_tgt_in[0] = tgt_x;
    assign w_tgt_in[1] = tgt_y;
    assign w_tgt_in[2] = tgt_z;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Per-axis datapath: clamp, deadband test, and one slew step.
    // Differences use one extra bit so full-range swings cannot overflow.
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        logic signed [W:0] w_band_diff;
        logic signed [W:0] w_band_abs;
        logic signed [W:0] w_err;
        logic signed [W:0] w_err_abs;

        assign w_clamped[gi] = (w_tgt_in[gi] > LIM_HI) ? LIM_HI :
                               (w_tgt_in[gi] < LIM_LO) ? LIM_LO : w_tgt_in[gi];

        assign w_band_diff   = $signed({w_clamped[gi][W-1], w_clamped[gi]})
                             - $signed({r_cmd[gi][W-1], r_cmd[gi]});
        assign w_band_abs    = w_band_diff[W] ? -w_band_diff : w_band_diff;
        assign w_in_band[gi] = (w_band_abs < THR_X);

        assign w_err         = $signed({r_tgt[gi][W-1], r_tgt[gi]})
                             - $signed({r_cmd[gi][W-1], r_cmd[gi]});
        assign w_err_abs     = w_err[W] ? -w_err : w_err;
        assign w_stepped[gi] = (w_err_abs <= STEP_X) ? r_tgt[gi] :
                               (w_err[W] ? (r_cmd[gi] - STEP_W) : (r_cmd[gi] + STEP_W));
        assign w_arrive[gi]  = (w_stepped[gi] == r_tgt[gi]);
    end

    // Next-state, target latch, slew and completion logic.
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        w_done_next   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_cmd_next[i] = r_cmd[i];
            w_tgt_next[i] = r_tgt[i];
        end
        case (r_state)
            S_IDLE: begin
                if (tgt_valid && !stop) begin
                    for (int i = 0; i < 3; i++) w_tgt_next[i] = w_clamped[i];
                    if (&w_in_band) w_done_next  = 1'b1;
                    else            w_state_next = S_MOVE;
                end
            end
            S_MOVE: begin
                if (stop) begin
                    // Abort: freeze where we are and forget the old target.
                    w_state_next = S_IDLE;
                    for (int i = 0; i < 3; i++) w_tgt_next[i] = r_cmd[i];
                end else if (w_tick) begin
                    for (int i = 0; i < 3; i++) w_cmd_next[i] = w_stepped[i];
                    if (&w_arrive) begin
                        w_state_next  = S_SETTLE;
                        w_settle_next = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                    for (int i = 0; i < 3; i++) w_tgt_next[i] = r_cmd[i];
                end else if (w_tick) begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_settle_next = r_settle_cnt + SW'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, counters and angle registers; the tick divider free-runs in all states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_settle_cnt <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_cmd[i] <= RST_ANG;
                r_tgt[i] <= RST_ANG;
            end
        end else begin
            r_state      <= w_state_next;
            r_tick_cnt   <= w_tick ? '0 : (r_tick_cnt + TW'(1));
            r_settle_cnt <= w_settle_next;
            r_done       <= w_done_next;
            for (int i = 0; i < 3; i++) begin
                r_cmd[i] <= w_cmd_next[i];
                r_tgt[i] <= w_tgt_next[i];
            end
        end
    end

    assign tgt_ready = (r_state == S_IDLE) && !stop;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign cmd_x     = r_cmd[0];
    assign cmd_y     = r_cmd[1];
    assign cmd_z     = r_cmd[2];

endmodule

// File: doc/servo_motion_sequencer.md
# servo_motion_sequencer

Motion controller that sits in front of `pwm_servos` in the robotic-arm datapath. It accepts 3-axis target angles (x, y, z) through a valid/ready handshake and clamps them to the mechanical range. It ramps its commanded angle outputs toward the targets at a fixed slew rate, then holds for a settle interval and signals completion. Its `cmd_x/y/z` outputs drive the `x/y/z` inputs of the PWM block directly, so the servos never see step changes larger than one slew step per update tick.

## Interface
- `FREQ`, 25_000_000: clock frequency in Hz (informational; used only for the default of `TICK_DIV`).
- `BIT_SIZE`, 10: width of the signed angle buses.
- `TICK_DIV`, 250_000: clocks per motion update tick (100 Hz at 25 MHz).
- `STEP_DEG`, 5: maximum angle change per axis per tick, in degrees.
- `COORD_MAX`, 270: clamp limit; targets are limited to [-COORD_MAX, +COORD_MAX].
- `RESET_ANGLE`, 90: commanded angle on all axes after reset.
- `THRESHOLD`, 10: deadband in degrees.
- `SETTLE_TICKS`, 10: ticks to hold after motion before `done`.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tgt_x`, `tgt_y`, `tgt_z`  in  BIT_SIZE signed  target angles.
- `tgt_valid`  in  1  target bus valid.
- `tgt_ready`  out  1  block can accept a target.
- `stop`  in  1  abort motion and hold the current position.
- `cmd_x`, `cmd_y`, `cmd_z`  out  BIT_SIZE signed  registered commanded angles to the PWM block.
- `busy`  out  1  high in MOVE or SETTLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, MOVE, SETTLE.
- Reset (rst=0) state:
  - State = IDLE.
  - `cmd_*` = RESET_ANGLE.
  - Latched targets = RESET_ANGLE.
  - Tick counter = 0, settle counter = 0.
  - `busy` = 0, `done` = 0.
  - `tgt_ready` = 1 while `stop` = 0.
- Ready: `tgt_ready` = (state == IDLE) && !stop. It is combinational from the state register and `stop`.
- Accept: `tgt_valid && tgt_ready` on a rising edge.
  - Each target is clamped to ±COORD_MAX and latched.
  - If every axis satisfies |clamped − cmd| < THRESHOLD, there is no motion: state stays IDLE and `done` pulses on the next cycle.
  - Otherwise the next state is MOVE.
- MOVE, on each tick cycle, for each axis:
  - err = tgt − cmd, computed at BIT_SIZE+1 bits signed.
  - If |err| ≤ STEP_DEG, then cmd = tgt.
  - Otherwise cmd moves by ±STEP_DEG toward tgt.
  - All axes update on the same tick.
  - When all axes equal their targets after the update, go to SETTLE and clear the settle counter.
- SETTLE: the settle counter increments on each tick. After SETTLE_TICKS ticks, go to IDLE and pulse `done` for exactly one cycle, coincident with the return to IDLE.
- Stop: `stop` = 1 in MOVE or SETTLE means next cycle is IDLE.
  - `cmd_*` hold their current values and latched targets are set equal to `cmd_*`.
  - No `done` pulse.
  - `stop` in IDLE blocks acceptance only.
- Tick counter: free-running from 0 to TICK_DIV−1 and wraps to 0. The tick strobe is asserted when count == TICK_DIV−1. It runs in all states and is not restarted by accept.
- Reset mid-operation: all outputs return immediately (asynchronously) to their reset values and any in-flight target is discarded.
- Simultaneous tick and `stop` in MOVE: `stop` wins and no step is applied on that cycle.

## Timing
- Accept at edge N: state = MOVE and `busy` = 1 after edge N; the first step lands on the first tick edge after N.
- Slew: an axis with distance D reaches its target after ceil(D/STEP_DEG) ticks. Total motion time is set by the largest-distance axis.
- `done` rises SETTLE_TICKS ticks after entry to SETTLE. `tgt_ready` is high in the same cycle as `done`.
- Deadband accept: `done` is high in cycle N+1; `busy` never asserts.
- `cmd_*` change only on tick edges, or on reset.

## Test plan
Tests 2 through 6 use TICK_DIV=4, STEP_DEG=5, SETTLE_TICKS=2.

1. **Reset.** Hold rst=0, then release. Required: `cmd_*` = 90/90/90, `tgt_ready` = 1, `busy` = 0, `done` = 0, with no change for 20 cycles.
2. **Single-axis move.** Accept (100,90,90). Required: `cmd_x` goes 90→95→100 on consecutive ticks; after 2 more ticks `done` pulses for 1 cycle; `busy` falls with it; y and z stay at 90.
3. **Deadband.** Accept (95,85,99) from 90/90/90. Required: no `cmd` change, `busy` = 0, `done` = 1 on the next cycle.
4. **Clamp and partial step.** Accept (−300,92,90). Required:
   - `cmd_x` ramps down by 5 per tick to −270 exactly.
   - `cmd_y` goes 90→92 on the first tick.
   - `done` pulses after the SETTLE phase.
5. **Stop mid-move.** Accept (200,90,90); assert `stop` when `cmd_x` = 120. Required: IDLE next cycle, `cmd_x` holds 120, no `done`; `tgt_ready` = 1 once `stop` drops.
6. **Async reset mid-move.** Pull rst low between clock edges during MOVE. Required: `cmd_*` = 90 and `busy` = 0 immediately; after release, a new accept proceeds normally.
